// File: rtl/fp_pkg.sv
// Shared floating-point constants and the packed single-precision word layout
// used by the normalise/pack stage and its leading-zero decoder.
package fp_pkg;
    localparam int MANT_W_DEF = 24;
    localparam int EXP_W_DEF  = 8;
    localparam int LZ_W       = 5;
    localparam int EXP_BIAS   = 127;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int FRAC_HI  = 22;
    localparam int FRAC_LO  = 0;

    // Field order matches bits 31 / 30:23 / 22:0 of the packed word.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;
endpackage

// File: rtl/fp_norm_pack_lzc.sv
// 24-bit leading-zero decoder plus a wrapper that adds the all-zero flag.
// lz reads as 0 for a zero mantissa; the zero flag disambiguates.
module lzc24
    import fp_pkg::*;
(
    input  logic [23:0]     i_mant,
    output logic [LZ_W-1:0] o_lz
);
    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        o_lz = '0;
        for (int i = 0; i < 24; i++) begin
            if (i_mant[i]) o_lz = LZ_W'(23 - i);
        end
    end
endmodule

module fp_norm_pack_lzc
    import fp_pkg::*;
(
    input  logic [23:0]     i_mant,
    output logic [LZ_W-1:0] o_lz,
    output logic            o_zero
);
    lzc24 u_lzc24 (
        .i_mant (i_mant),
        .o_lz   (o_lz)
    );

    assign o_zero = (i_mant == 24'd0);
endmodule

// File: rtl/fp_norm_pack.sv
// Two-stage normalise-and-pack: stage 1 registers the operand with its
// leading-zero count, stage 2 shifts, adjusts the exponent and packs.
module fp_norm_pack
    import fp_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_zero,
    output logic              out_uf,
    output logic [CNT_W-1:0]  uf_count,
    input  logic              uf_clr
);
    // valid/ready: a word moves across an interface on the rising edge where
    // valid && ready; a producer holds valid and data stable until that edge.

    logic              r_s1_valid;
    logic              r_s1_sign;
    logic [EXP_W-1:0]  r_s1_exp;
    logic [MANT_W-1:0] r_s1_mant;
    logic [LZ_W-1:0]   r_s1_lz;
    logic              r_s1_zero;

    logic              r_out_valid;
    logic [31:0]       r_out_data;
    logic              r_out_zero;
    logic              r_out_uf;
    logic [CNT_W-1:0]  r_uf_count;

    logic [LZ_W-1:0]   w_lz;
    logic              w_mant_zero;
    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_uf_xfer;
    logic [MANT_W-1:0] w_shifted;
    logic [EXP_W-1:0]  w_exp_adj;
    fp32_t             w_s2_word;
    logic              w_s2_zero;
    logic              w_s2_uf;

    fp_norm_pack_lzc u_lzc (
        .i_mant (in_mant),
        .o_lz   (w_lz),
        .o_zero (w_mant_zero)
    );

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_shifted = r_s1_mant << r_s1_lz;
    assign w_exp_adj = r_s1_exp - EXP_W'(r_s1_lz);

    // Guard exp <= lz keeps the exponent subtraction from wrapping.
    always_comb begin
        w_s2_word      = '0;
        w_s2_word.sign = r_s1_sign;
        w_s2_zero      = 1'b0;
        w_s2_uf        = 1'b0;
        if (r_s1_exp == EXP_W'(EXP_MAX)) begin
            w_s2_word.exp  = r_s1_exp;
            w_s2_word.frac = r_s1_mant[MANT_W-2:0];
        end else if (r_s1_zero) begin
            w_s2_zero = 1'b1;
        end else if (r_s1_exp <= EXP_W'(r_s1_lz)) begin
            w_s2_zero = 1'b1;
            w_s2_uf   = 1'b1;
        end else begin
            w_s2_word.exp  = w_exp_adj;
            w_s2_word.frac = w_shifted[MANT_W-2:0];
        end
    end

    assign w_uf_xfer = r_out_valid && out_ready && r_out_uf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_mant   <= '0;
            r_s1_lz     <= '0;
            r_s1_zero   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_zero  <= 1'b0;
            r_out_uf    <= 1'b0;
            r_uf_count  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_sign <= in_sign;
                    r_s1_exp  <= in_exp;
                    r_s1_mant <= in_mant;
                    r_s1_lz   <= w_lz;
                    r_s1_zero <= w_mant_zero;
                end
            end
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_s2_word;
                    r_out_zero <= w_s2_zero;
                    r_out_uf   <= w_s2_uf;
                end
            end
            if (uf_clr) begin
                r_uf_count <= '0;
            end else if (w_uf_xfer && (r_uf_count != {CNT_W{1'b1}})) begin
                r_uf_count <= r_uf_count + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_zero  = r_out_zero;
    assign out_uf    = r_out_uf;
    assign uf_count  = r_uf_count;
endmodule

// File: tb/tb_fp_norm_pack.sv
// Bench for fp_norm_pack: directed vector table with exact latency checks,
// backpressure/reset/saturation sequences, and randomized traffic vs a model.
module tb_fp_norm_pack;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sign = 1'b0;
    logic [7:0]    in_exp = '0;
    logic [23:0]   in_mant = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic          out_zero;
    logic          out_uf;
    logic [CW-1:0] uf_count;
    logic          uf_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_accept = 0;
    int n_out = 0;
    int mode = 0;
    logic clr_req = 1'b0;

    logic [33:0]   exp_q[$];
    logic [CW-1:0] m_cnt = '0;
    logic          prev_stall = 1'b0;
    logic [33:0]   prev_word = '0;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic [31:0] d;
        logic        z;
        logic        u;
    } vec_t;
    vec_t vecs[11];

    fp_norm_pack #(.MANT_W(24), .EXP_W(8), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_uf    (out_uf),
        .uf_count  (uf_count),
        .uf_clr    (uf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: normalise by doubling until the hidden bit is reached.
    function automatic logic [33:0] model(input logic s, input logic [7:0] e, input logic [23:0] m);
        int mm;
        int sh;
        if (e == 8'hFF) return {s, e, m[22:0], 2'b00};
        if (m == 24'd0) return {s, 31'b0, 2'b10};
        mm = int'(m);
        sh = 0;
        while (mm < 32'h800000) begin
            mm = mm * 2;
            sh++;
        end
        if (int'(e) <= sh) return {s, 31'b0, 2'b11};
        return {s, 8'(int'(e) - sh), 23'(mm - 32'h800000), 2'b00};
    endfunction

    // out_ready / uf_clr driver, updated 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            uf_clr = clr_req || (mode == 2 && $urandom_range(0, 19) == 0);
        end
    end

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [33:0] e;
        logic        xfer;
        logic        exp_uf;
        if (rst) begin
            m_cnt      = '0;
            prev_stall = 1'b0;
        end else begin
            chk("uf_count", 64'(uf_count), 64'(m_cnt));
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_word", 64'({out_data, out_zero, out_uf}), 64'(prev_word));
            end
            xfer   = out_valid && out_ready;
            exp_uf = 1'b0;
            if (xfer) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out actual=%0h required=none at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    exp_uf = e[0];
                    if ({out_data, out_zero, out_uf} !== e) begin
                        failures++;
                        $display("FAIL out_word actual=%0h required=%0h at %0t",
                                 {out_data, out_zero, out_uf}, e, $time);
                    end
                end
            end
            if (uf_clr) m_cnt = '0;
            else if (xfer && exp_uf && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_data, out_zero, out_uf};
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m);
        int t = 0;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (t >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accept at %0t", $time);
        end
        @(posedge clk);
        if (t < 200) begin
            exp_q.push_back(model(s, e, m));
            n_accept++;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 64'(t < 500), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        @(negedge clk);
        chk("uf_clr_zero", 64'(uf_count), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int outs_before;
        vecs[0]  = '{1'b0, 8'h7F, 24'h800000, 32'h3F800000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h85, 24'h400000, 32'h42000000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h40, 24'h000000, 32'h80000000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h40, 24'h000000, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h03, 24'h000010, 32'h00000000, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'hFF, 24'h400000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h81, 24'h000001, 32'hB5000000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h01, 24'h400000, 32'h00000000, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'h02, 24'h400000, 32'h00800000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'hFF, 24'h000000, 32'h7F800000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 24'h800000, 32'h80000000, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_out_uf", 64'(out_uf), 64'd0);
        chk("rst_uf_count", 64'(uf_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors, one at a time, with exact two-cycle latency
        mode = 0;
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].s, vecs[i].e, vecs[i].m);
            @(negedge clk);
            chk($sformatf("vec%0d_early", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].d));
            chk($sformatf("vec%0d_zero", i), 64'(out_zero), 64'(vecs[i].z));
            chk($sformatf("vec%0d_uf", i), 64'(out_uf), 64'(vecs[i].u));
            @(posedge clk);
            #1;
        end
        drain();
        chk("uf_count_after_vecs", 64'(uf_count), 64'd3);

        // Backpressure: out_ready low for 5 edges while 4 inputs are offered
        mode = 1;
        n_accept = 0;
        outs_before = n_out;
        fork
            begin
                send(1'b0, 8'h90, 24'h000F00);
                send(1'b1, 8'h10, 24'h020000);
                send(1'b0, 8'h05, 24'h000100);
                send(1'b1, 8'hFF, 24'h123456);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("bp_accepts", 64'(n_accept), 64'd2);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                mode = 0;
            end
        join
        drain();
        chk("bp_out_count", 64'(n_out - outs_before), 64'd4);

        // Underflow counter saturation, then clear
        clr_pulse();
        for (int i = 0; i < 18; i++) send(1'b0, 8'h03, 24'h000010);
        drain();
        chk("uf_saturated", 64'(uf_count), 64'(4'hF));
        clr_pulse();

        // Reset with two words in flight
        mode = 1;
        send(1'b0, 8'h20, 24'h000333);
        send(1'b1, 8'h30, 24'h0000F1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        outs_before = n_out;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mode = 0;
        send(1'b0, 8'h7F, 24'h123456);
        drain();
        chk("midrst_out_count", 64'(n_out - outs_before), 64'd1);

        // Randomized traffic with random backpressure and clears
        mode = 2;
        for (int i = 0; i < 200; i++) begin
            logic [7:0]  e;
            logic [23:0] m;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 2) e = 8'hFF;
            else if (sel < 5) e = 8'($urandom_range(0, 25));
            else e = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 6) == 0) m = 24'd0;
            else m = 24'($urandom) >> $urandom_range(0, 23);
            send(1'($urandom_range(0, 1)), e, m);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        mode = 0;
        drain();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_norm_pack.md
Name: fp_norm_pack

Overview:
- Normalisation and pack stage that sits directly downstream of the 24-bit leading-zero decoder in the radix-3 floating-point datapath.
- Accepts an unnormalised sign/exponent/mantissa result from the butterfly adder and computes its leading-zero count.
- Shifts the mantissa so the hidden bit lands at bit 23, adjusts the exponent, and emits a packed 32-bit single-precision word.
- Two-stage pipeline with valid/ready backpressure; also keeps a saturating underflow event counter for status.

Parameters:
- MANT_W, 24, mantissa width including hidden-bit position (bit 23).
- EXP_W, 8, exponent width, bias 127.
- CNT_W, 16, width of the underflow event counter.

Ports:
- clk  input  1  single clock; all state is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  stage can accept an input this cycle.
- in_sign  input  1  sign of result.
- in_exp  input  EXP_W  biased exponent before normalisation.
- in_mant  input  MANT_W  unnormalised mantissa; bit 23 is the hidden-bit position.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  packed {sign, exp[7:0], frac[22:0]}.
- out_zero  output  1  result is a signed zero (zero mantissa or flushed).
- out_uf  output  1  result was flushed due to exponent underflow.
- uf_count  output  CNT_W  saturating count of underflow results delivered.
- uf_clr  input  1  synchronous clear of uf_count.

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_zero=0, out_uf=0, uf_count=0. in_ready=1 combinationally once reset releases.
- Handshake: a transfer occurs on the clk edge where valid&&ready. in_valid must be held with stable data until accepted. out_data, out_zero and out_uf stay stable while out_valid && !out_ready.
- Stage 1: register sign, exp, mant and the 5-bit leading-zero count lz.
  - lz semantics: lz=0 when mant[23]=1; lz=k when the first 1 is at bit 23-k; lz=0 for mant==0.
  - Detect mant_zero = (mant==0) separately.
- Stage 2: compute and register the packed result.
  - exp==255: pass through unshifted; frac=mant[22:0]; out_zero=0; out_uf=0.
  - else if mant_zero: out_data={sign,31'b0}; out_zero=1; out_uf=0.
  - else if exp <= lz (unsigned compare): flush to {sign,31'b0}; out_zero=1; out_uf=1.
  - else: m=mant<<lz; exp_out=exp-lz (8-bit, cannot wrap given the guard above); frac=m[22:0].
- Latency: exactly 2 cycles from the input transfer to out_valid with no stall. Throughput is 1 word per cycle.
- Backpressure:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - Up to 2 words are held internally. No word is dropped or reordered.
- Simultaneous events:
  - Full pipeline with out_ready=1 and in_valid=1: all three move in the same cycle.
  - A bubble in stage 1 is collapsed when stage 2 is stalled.
- uf_count: increments by 1 on each output transfer with out_uf=1 and saturates at all-ones.
  - uf_clr has priority: if uf_clr is asserted in the same cycle as an underflow transfer, the result is 0.
- Reset mid-operation: in-flight words are discarded. The first output after reset comes from the first input accepted after reset.

Decomposition:
- Shared package fp_pkg: bias constant (127), EXP_MAX (255), the packed-word field layout (sign bit 31, exp 30:23, frac 22:0), and the MANT_W/EXP_W defaults.
- Sub-module lzc24: the team's combinational 24-bit leading-zero decoder, instantiated once in stage 1. It sits behind a wrapper that adds the mant_zero flag.
- The shifter and pipeline registers stay in fp_norm_pack.

Test Plan:
- Already normal: sign0, exp 0x7F, mant 0x800000 -> out_data 0x3F800000 two cycles later; out_zero=0, out_uf=0.
- One-bit shift: sign0, exp 0x85, mant 0x400000 (lz=1) -> 0x42000000 (32.0).
- Zero mantissa: sign1, exp 0x40, mant 0 -> 0x80000000, out_zero=1, out_uf=0. Same with sign0 -> 0x00000000.
- Underflow: exp 0x03, mant 0x000010 (lz=19) -> 0x00000000, out_zero=1, out_uf=1, uf_count 0->1. Repeat at all-ones count -> stays saturated. uf_clr pulse -> 0.
- Special pass-through: exp 0xFF, mant 0x400000 -> 0x7FC00000, no shift, out_uf=0.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles while driving 4 back-to-back inputs -> in_ready drops after 2 accepts; all 4 outputs later appear in order with no loss.
  - Assert rst with 2 words in flight -> out_valid=0 immediately, and neither discarded word ever appears at the output.
